qei_filtered: RTL and testbench

Parametrised next-generation quadrature encoder interface: one encoder channel, configurable position width, per-input glitch filter, index handling, illegal-transition detection and windowed velocity measurement. It sits between the encoder input pins and the position/velocity register interface and replaces the fixed 32-bit `qei` for new motor axes. All logic runs on one clock; encoder inputs are asynchronous to it.

---
 rtl/qei_filtered.sv | 208 ++++++++++++++++++++
 tb/tb_qei_filtered.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qei_filtered.sv
// qei_filtered: filtered quadrature encoder interface with index,
// illegal-transition flag and windowed signed velocity.
module qei_filtered #(
  parameter int WIDTH     = 32,
  parameter int FILTER    = 4,
  parameter int WINDOW    = 1000000,
  parameter int VEL_WIDTH = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [1:0]                  qei_quad,
  input  logic                        qei_index,
  input  logic                        index_clear_en,
  input  logic                        load,
  input  logic [WIDTH-1:0]            load_value,
  input  logic                        error_clear,
  output logic [WIDTH-1:0]            qei_position,
  output logic signed [VEL_WIDTH-1:0] qei_velocity,
  output logic                        velocity_valid,
  output logic                        index_seen,
  output logic                        qei_error
);

  localparam int FCW = $clog2(FILTER + 1);
  localparam int ICW = $clog2(FILTER + 4);
  localparam int WCW = $clog2(WINDOW);

  localparam logic [FCW-1:0] FLAST = FCW'(FILTER - 1);
  localparam logic [FCW-1:0] FONE  = FCW'(1);
  localparam logic [ICW-1:0] INH   = ICW'(FILTER + 3);
  localparam logic [ICW-1:0] IONE  = ICW'(1);
  localparam logic [WCW-1:0] WLAST = WCW'(WINDOW - 1);
  localparam logic [WCW-1:0] WONE  = WCW'(1);
  localparam logic [WIDTH-1:0] PONE = WIDTH'(1);

  localparam logic [VEL_WIDTH-1:0] VMAX =
    {1'b0, {(VEL_WIDTH-1){1'b1}}};
  localparam logic [VEL_WIDTH-1:0] VMIN =
    {1'b1, {(VEL_WIDTH-1){1'b0}}};

  // bit 2 is the index, bits 1:0 the quad phases
  logic [2:0]          s1_q, s2_q;
  logic [2:0]          flt_q, flt_d;
  logic [2:0][FCW-1:0] cnt_q, cnt_d;
  logic [2:0]          now_q, last_q;
  logic [ICW-1:0]      inh_q;
  logic                inhibit;

  logic [1:0] lq, nq;
  logic       up, dn, illegal, idx_rise;

  logic [WIDTH-1:0]     pos_q, pos_d;
  logic                 seen_q, seen_d;
  logic                 err_q, err_d;
  logic [WCW-1:0]       win_q, win_d;
  logic [VEL_WIDTH-1:0] acc_q, acc_d;
  logic [VEL_WIDTH-1:0] vel_q, vel_d;
  logic                 vld_q, vld_d;
  logic [VEL_WIDTH:0]   step_ext, sum;
  logic [VEL_WIDTH-1:0] sat;

  // two-flop synchroniser on all three raw inputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= {qei_index, qei_quad};
      s2_q <= s1_q;
    end
  end

  // per-bit stability filter: accept after FILTER differing samples
  always_comb begin
    flt_d = flt_q;
    cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (s2_q[i] != flt_q[i]) begin
        if (cnt_q[i] == FLAST) begin
          flt_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + FONE;
        end
      end
    end
  end

  // filter state
  always_ff @(posedge clock) begin
    if (!reset) begin
      flt_q <= '0;
      cnt_q <= '0;
    end else begin
      flt_q <= flt_d;
      cnt_q <= cnt_d;
    end
  end

  assign inhibit = (inh_q != INH);

  // decode pair; during startup both halves follow the filter output
  always_ff @(posedge clock) begin
    if (!reset) begin
      now_q  <= '0;
      last_q <= '0;
      inh_q  <= '0;
    end else begin
      now_q  <= flt_q;
      last_q <= inhibit ? flt_q : now_q;
      if (inhibit) inh_q <= inh_q + IONE;
    end
  end

  assign lq = last_q[1:0];
  assign nq = now_q[1:0];

  // transition decode
  always_comb begin
    up       = 1'b0;
    dn       = 1'b0;
    illegal  = 1'b0;
    idx_rise = 1'b0;
    if (!inhibit) begin
      case ({lq, nq})
        4'b0001, 4'b0111,
        4'b1110, 4'b1000: up = 1'b1;
        4'b0100, 4'b1101,
        4'b1011, 4'b0010: dn = 1'b1;
        4'b0011, 4'b1100,
        4'b0110, 4'b1001: illegal = 1'b1;
        default: ;
      endcase
      idx_rise = now_q[2] & ~last_q[2];
    end
  end

  // position, index flag and error flag next state
  always_comb begin
    pos_d  = pos_q;
    seen_d = seen_q | idx_rise;
    err_d  = err_q;
    if (load) begin
      pos_d = load_value;
    end else if (idx_rise && index_clear_en) begin
      pos_d = '0;
    end else if (up) begin
      pos_d = pos_q + PONE;
    end else if (dn) begin
      pos_d = pos_q - PONE;
    end
    if (illegal) begin
      err_d = 1'b1;
    end else if (error_clear) begin
      err_d = 1'b0;
    end
  end

  // saturating window accumulator and velocity latch
  always_comb begin
    step_ext = '0;
    if (up) step_ext = {{VEL_WIDTH{1'b0}}, 1'b1};
    if (dn) step_ext = '1;
    sum = {acc_q[VEL_WIDTH-1], acc_q} + step_ext;
    sat = sum[VEL_WIDTH-1:0];
    if (sum[VEL_WIDTH] != sum[VEL_WIDTH-1]) begin
      sat = sum[VEL_WIDTH] ? VMIN : VMAX;
    end
    vel_d = vel_q;
    vld_d = 1'b0;
    if (win_q == WLAST) begin
      win_d = '0;
      acc_d = '0;
      vel_d = sat;
      vld_d = 1'b1;
    end else begin
      win_d = win_q + WONE;
      acc_d = sat;
    end
  end

  // output-side state
  always_ff @(posedge clock) begin
    if (!reset) begin
      pos_q  <= '0;
      seen_q <= 1'b0;
      err_q  <= 1'b0;
      win_q  <= '0;
      acc_q  <= '0;
      vel_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      seen_q <= seen_d;
      err_q  <= err_d;
      win_q  <= win_d;
      acc_q  <= acc_d;
      vel_q  <= vel_d;
      vld_q  <= vld_d;
    end
  end

  assign qei_position   = pos_q;
  assign qei_velocity   = vel_q;
  assign velocity_valid = vld_q;
  assign index_seen     = seen_q;
  assign qei_error      = err_q;

endmodule

// File: tb/tb_qei_filtered.sv
// tb_qei_filtered: scoreboard bench for qei_filtered
// (WIDTH=8, FILTER=4, WINDOW=100, VEL_WIDTH=4).
module tb_qei_filtered;

  localparam int W   = 8;
  localparam int F   = 4;
  localparam int WIN = 100;
  localparam int VW  = 4;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [1:0]           qei_quad;
  logic                 qei_index;
  logic                 index_clear_en;
  logic                 load;
  logic [W-1:0]         load_value;
  logic                 error_clear;
  logic [W-1:0]         qei_position;
  logic signed [VW-1:0] qei_velocity;
  logic                 velocity_valid;
  logic                 index_seen;
  logic                 qei_error;

  int checks   = 0;
  int failures = 0;
  int mpos     = 0;

  logic [W-1:0]         exp_q[$];
  logic signed [VW-1:0] vel_q[$];

  qei_filtered #(
    .WIDTH(W), .FILTER(F), .WINDOW(WIN), .VEL_WIDTH(VW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .qei_quad(qei_quad),
    .qei_index(qei_index),
    .index_clear_en(index_clear_en),
    .load(load),
    .load_value(load_value),
    .error_clear(error_clear),
    .qei_position(qei_position),
    .qei_velocity(qei_velocity),
    .velocity_valid(velocity_valid),
    .index_seen(index_seen),
    .qei_error(qei_error)
  );

  always #5 clock = ~clock;

  function automatic logic [1:0] nxt(input logic [1:0] q,
                                     input bit up);
    logic [1:0] r;
    if (up) begin
      case (q)
        2'b00: r = 2'b01;
        2'b01: r = 2'b11;
        2'b11: r = 2'b10;
        default: r = 2'b00;
      endcase
    end else begin
      case (q)
        2'b00: r = 2'b10;
        2'b10: r = 2'b11;
        2'b11: r = 2'b01;
        default: r = 2'b00;
      endcase
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input bit up);
    qei_quad = nxt(qei_quad, up);
    mpos = (mpos + (up ? 1 : -1)) & 255;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    qei_quad = 2'b11;
    repeat (3) tick();
    checks += 5;
    if (qei_position !== 8'd0) begin
      failures++;
      $display("FAIL rst_pos actual=%0d required=0", qei_position);
    end
    if (qei_velocity !== 4'sd0) begin
      failures++;
      $display("FAIL rst_vel actual=%0d required=0", qei_velocity);
    end
    if (velocity_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_vld actual=%b required=0", velocity_valid);
    end
    if (index_seen !== 1'b0) begin
      failures++;
      $display("FAIL rst_seen actual=%b required=0", index_seen);
    end
    if (qei_error !== 1'b0) begin
      failures++;
      $display("FAIL rst_err actual=%b required=0", qei_error);
    end
    reset = 1'b1;
    mpos = 0;
    exp_q.push_back(8'd0);
    repeat (20) tick();
    checks += 2;
    begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      if (qei_position !== e) begin
        failures++;
        $display("FAIL start_pos actual=%0d required=%0d",
                 qei_position, e);
      end
    end
    if (qei_error !== 1'b0) begin
      failures++;
      $display("FAIL start_err actual=%b required=0", qei_error);
    end
  endtask

  task automatic test_forward();
    logic [W-1:0] old;
    logic [W-1:0] e;
    old = W'(mpos);
    step(1'b1);
    exp_q.push_back(W'(mpos));
    repeat (7) tick();
    checks++;
    if (qei_position !== old) begin
      failures++;
      $display("FAIL latency_early actual=%0d required=%0d",
               qei_position, old);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (qei_position !== e) begin
      failures++;
      $display("FAIL latency_edge actual=%0d required=%0d",
               qei_position, e);
    end
    repeat (2) tick();
    for (int i = 0; i < 10; i++) begin
      step(i < 7);
      exp_q.push_back(W'(mpos));
      repeat (10) tick();
      e = exp_q.pop_front();
      checks++;
      if (qei_position !== e) begin
        failures++;
        $display("FAIL step_%0d actual=%0d required=%0d",
                 i, qei_position, e);
      end
    end
    checks++;
    if (qei_position !== 8'd5) begin
      failures++;
      $display("FAIL fwd_rev_total actual=%0d required=5",
               qei_position);
    end
  endtask

  task automatic test_glitch();
    logic [W-1:0] e;
    exp_q.push_back(W'(mpos));
    qei_quad[0] = ~qei_quad[0];
    repeat (3) tick();
    qei_quad[0] = ~qei_quad[0];
    repeat (12) tick();
    e = exp_q.pop_front();
    checks += 2;
    if (qei_position !== e) begin
      failures++;
      $display("FAIL glitch_pos actual=%0d required=%0d",
               qei_position, e);
    end
    if (qei_error !== 1'b0) begin
      failures++;
      $display("FAIL glitch_err actual=%b required=0", qei_error);
    end
    exp_q.push_back(W'(mpos));
    qei_quad = ~qei_quad;
    repeat (10) tick();
    e = exp_q.pop_front();
    checks += 2;
    if (qei_error !== 1'b1) begin
      failures++;
      $display("FAIL illegal_err actual=%b required=1", qei_error);
    end
    if (qei_position !== e) begin
      failures++;
      $display("FAIL illegal_pos actual=%0d required=%0d",
               qei_position, e);
    end
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    checks++;
    if (qei_error !== 1'b0) begin
      failures++;
      $display("FAIL err_clear actual=%b required=0", qei_error);
    end
    qei_quad = ~qei_quad;
    repeat (7) tick();
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    checks++;
    if (qei_error !== 1'b1) begin
      failures++;
      $display("FAIL set_wins actual=%b required=1", qei_error);
    end
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_load_wrap();
    logic [W-1:0] e;
    load = 1'b1;
    load_value = 8'd255;
    mpos = 255;
    exp_q.push_back(W'(mpos));
    tick();
    load = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (qei_position !== e) begin
      failures++;
      $display("FAIL load actual=%0d required=%0d",
               qei_position, e);
    end
    for (int i = 0; i < 2; i++) begin
      step(i == 0);
      exp_q.push_back(W'(mpos));
      repeat (10) tick();
      e = exp_q.pop_front();
      checks++;
      if (qei_position !== e) begin
        failures++;
        $display("FAIL wrap_%0d actual=%0d required=%0d",
                 i, qei_position, e);
      end
    end
  endtask

  task automatic test_index();
    logic [W-1:0] e;
    load = 1'b1;
    load_value = 8'd37;
    tick();
    load = 1'b0;
    mpos = 37;
    index_clear_en = 1'b1;
    checks++;
    if (index_seen !== 1'b0) begin
      failures++;
      $display("FAIL seen_pre actual=%b required=0", index_seen);
    end
    qei_index = 1'b1;
    step(1'b1);
    mpos = 0;
    exp_q.push_back(W'(mpos));
    repeat (6) tick();
    qei_index = 1'b0;
    repeat (10) tick();
    e = exp_q.pop_front();
    checks += 2;
    if (qei_position !== e) begin
      failures++;
      $display("FAIL idx_clear actual=%0d required=%0d",
               qei_position, e);
    end
    if (index_seen !== 1'b1) begin
      failures++;
      $display("FAIL seen_set actual=%b required=1", index_seen);
    end
    index_clear_en = 1'b0;
    load = 1'b1;
    tick();
    load = 1'b0;
    mpos = 37;
    qei_index = 1'b1;
    step(1'b1);
    exp_q.push_back(W'(mpos));
    repeat (6) tick();
    qei_index = 1'b0;
    repeat (10) tick();
    e = exp_q.pop_front();
    checks += 2;
    if (qei_position !== e) begin
      failures++;
      $display("FAIL idx_noclear actual=%0d required=%0d",
               qei_position, e);
    end
    if (index_seen !== 1'b1) begin
      failures++;
      $display("FAIL seen_hold actual=%b required=1", index_seen);
    end
  endtask

  task automatic test_velocity();
    logic [W-1:0] e;
    int pulses;
    pulses = 0;
    reset = 1'b0;
    qei_quad = 2'b00;
    qei_index = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    mpos = 0;
    fork
      begin
        vel_q.push_back(4'sd5);
        repeat (4) tick();
        for (int i = 0; i < 5; i++) begin
          step(1'b1);
          repeat (10) tick();
        end
        vel_q.push_back(-4'sd8);
        repeat (50) tick();
        for (int i = 0; i < 12; i++) begin
          step(1'b0);
          repeat (6) tick();
        end
        vel_q.push_back(4'sd0);
      end
      begin
        for (int n = 1; n <= 305; n++) begin
          logic want;
          logic signed [VW-1:0] ev;
          tick();
          want = ((n % WIN) == 0);
          checks++;
          if (velocity_valid !== want) begin
            failures++;
            $display("FAIL vld_cycle_%0d actual=%b required=%b",
                     n, velocity_valid, want);
          end
          if (velocity_valid === 1'b1) begin
            pulses++;
            checks++;
            if (vel_q.size() == 0) begin
              failures++;
              $display("FAIL vel_unexpected actual=%0d required=none",
                       qei_velocity);
            end else begin
              ev = vel_q.pop_front();
              if (qei_velocity !== ev) begin
                failures++;
                $display("FAIL vel_win_%0d actual=%0d required=%0d",
                         pulses, qei_velocity, ev);
              end
            end
          end
        end
      end
    join
    checks++;
    if (pulses != 3) begin
      failures++;
      $display("FAIL vel_pulses actual=%0d required=3", pulses);
    end
    exp_q.push_back(W'(mpos));
    e = exp_q.pop_front();
    checks++;
    if (qei_position !== e) begin
      failures++;
      $display("FAIL vel_pos actual=%0d required=%0d",
               qei_position, e);
    end
  endtask

  initial begin
    reset          = 1'b0;
    qei_quad       = 2'b00;
    qei_index      = 1'b0;
    index_clear_en = 1'b0;
    load           = 1'b0;
    load_value     = '0;
    error_clear    = 1'b0;
    test_reset();
    test_forward();
    test_glitch();
    test_load_wrap();
    test_index();
    test_velocity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
